// File: rtl/xcorr_spec_mult.sv
// xcorr_spec_mult
// Streaming complex spectral multiplier for the FFT cross-correlator. Each
// input bin is multiplied by the stored reference spectrum of the frame's tag
// (plain or conjugated). The result is rounded, saturated and forwarded
// downstream. The pipeline has four register stages and advances globally.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   s_axis_tvalid/tready       input handshake (tready = global advance)
//   s_axis_tdata  [2*DW]       {Q,I}
//   s_axis_tuser  [TAG_W+1]    {conj_en, tag}, used on the first beat only
//   s_axis_tlast               last bin of the frame
//   c_wr_en/tag/addr/data      coefficient write port, data = {Ci,Cr}
//   m_axis_tvalid/tready       output handshake
//   m_axis_tdata  [2*OW]       {Q,I} product
//   m_axis_tuser  [TAG_W+1]    {sat, tag}
//   m_axis_tlast               tlast carried with the beat
//   frame_err                  one-cycle pulse after an offending beat
//
// state | meaning
// IDLE  | waiting for the first beat of a frame; tuser is taken from the bus
// FRAME | mid-frame; tag/conj_en come from the latched copy
module xcorr_spec_mult #(
   parameter int NUM_TAGS = 20,
   parameter int FFT_LEN  = 1024,
   parameter int DW       = 16,
   parameter int CW       = 16,
   parameter int OW       = 16,
   parameter int SHIFT    = 15,
   localparam int TAG_W   = $clog2(NUM_TAGS + 1),
   localparam int AW      = $clog2(FFT_LEN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic [2*DW-1:0]     s_axis_tdata,
   input  logic [TAG_W:0]      s_axis_tuser,
   input  logic                s_axis_tlast,
   input  logic                c_wr_en,
   input  logic [TAG_W-1:0]    c_wr_tag,
   input  logic [AW-1:0]       c_wr_addr,
   input  logic [2*CW-1:0]     c_wr_data,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic [2*OW-1:0]     m_axis_tdata,
   output logic [TAG_W:0]      m_axis_tuser,
   output logic                m_axis_tlast,
   output logic                frame_err
);

   localparam int PPW   = DW + CW;
   localparam int PW    = DW + CW + 1;
   localparam int RW    = PW + 1;
   localparam int DEPTH = NUM_TAGS * FFT_LEN;
   localparam int RAW   = $clog2(DEPTH);

   localparam logic [TAG_W-1:0]     TAG_LIM  = TAG_W'(NUM_TAGS);
   localparam logic [AW-1:0]        LAST_BIN = AW'(FFT_LEN - 1);
   localparam logic signed [RW-1:0] RND      = RW'(64'sd1 << (SHIFT - 1));
   localparam logic signed [RW-1:0] OMAX     = RW'((64'sd1 << (OW - 1)) - 1);
   localparam logic signed [RW-1:0] OMIN     = RW'(-(64'sd1 << (OW - 1)));
   localparam logic [OW-1:0]        OMAX_O   = OW'((64'sd1 << (OW - 1)) - 1);
   localparam logic [OW-1:0]        OMIN_O   = ~OMAX_O;

   typedef enum logic {IDLE, FRAME} state_t;

   state_t           state, state_nxt;
   logic [AW-1:0]    bin, bin_nxt;
   logic [TAG_W-1:0] tag_q, tag_nxt;
   logic             conj_q, conj_nxt;
   logic             err_nxt;

   logic             adv;
   logic             accept;
   logic [TAG_W-1:0] cur_tag;
   logic             cur_conj;
   logic             cur_bad;

   assign adv           = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = adv;
   assign accept        = s_axis_tvalid && adv;

   // ---------------- frame FSM ----------------
   always_comb begin
      state_nxt = state;
      bin_nxt   = bin;
      tag_nxt   = tag_q;
      conj_nxt  = conj_q;
      err_nxt   = 1'b0;
      cur_tag   = tag_q;
      cur_conj  = conj_q;
      if (state == IDLE) begin
         cur_tag  = s_axis_tuser[TAG_W-1:0];
         cur_conj = s_axis_tuser[TAG_W];
      end
      cur_bad = (cur_tag >= TAG_LIM);

      if (accept) begin
         if (state == IDLE) begin
            tag_nxt  = cur_tag;
            conj_nxt = cur_conj;
            err_nxt  = cur_bad;
         end
         if (s_axis_tlast) begin
            if (bin != LAST_BIN) err_nxt = 1'b1;
            state_nxt = IDLE;
            bin_nxt   = '0;
         end else begin
            // A long frame wraps the bin counter but keeps the frame's tag.
            if (bin == LAST_BIN) err_nxt = 1'b1;
            state_nxt = FRAME;
            bin_nxt   = bin + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bin       <= '0;
         tag_q     <= '0;
         conj_q    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         bin       <= bin_nxt;
         tag_q     <= tag_nxt;
         conj_q    <= conj_nxt;
         frame_err <= err_nxt;
      end
   end

   // ---------------- coefficient RAM ----------------
   // Word address {tag, bin} equals tag*FFT_LEN + bin since FFT_LEN is a
   // power of two. Read-before-write gives old data on a same-word collision.
   logic [2*CW-1:0]  mem [DEPTH];
   logic [2*CW-1:0]  coef_rd;
   logic [TAG_W-1:0] rd_tag;
   logic [RAW-1:0]   rd_addr;
   logic [RAW-1:0]   wr_addr;

   assign rd_tag  = cur_bad ? '0 : cur_tag;
   assign rd_addr = RAW'({rd_tag, bin});
   assign wr_addr = RAW'({c_wr_tag, c_wr_addr});

   always_ff @(posedge clk) begin
      if (c_wr_en && (c_wr_tag < TAG_LIM)) mem[wr_addr] <= c_wr_data;
      if (accept) coef_rd <= mem[rd_addr];
   end

   // ---------------- S0: input register ----------------
   logic                 s0_valid, s0_conj, s0_zero, s0_last;
   logic [TAG_W-1:0]     s0_tag;
   logic signed [DW-1:0] s0_i, s0_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_valid <= 1'b0;
         s0_conj  <= 1'b0;
         s0_zero  <= 1'b0;
         s0_last  <= 1'b0;
         s0_tag   <= '0;
         s0_i     <= '0;
         s0_q     <= '0;
      end else if (adv) begin
         s0_valid <= accept;
         if (accept) begin
            s0_conj <= cur_conj;
            s0_zero <= cur_bad;
            s0_last <= s_axis_tlast;
            s0_tag  <= cur_tag;
            s0_i    <= s_axis_tdata[DW-1:0];
            s0_q    <= s_axis_tdata[2*DW-1:DW];
         end
      end
   end

   // ---------------- S1: partial products ----------------
   logic signed [CW-1:0]  cr, ci;
   logic                  s1_valid, s1_conj, s1_last;
   logic [TAG_W-1:0]      s1_tag;
   logic signed [PPW-1:0] p_ir, p_qi, p_qr, p_ii;

   assign cr = s0_zero ? '0 : coef_rd[CW-1:0];
   assign ci = s0_zero ? '0 : coef_rd[2*CW-1:CW];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_conj  <= 1'b0;
         s1_last  <= 1'b0;
         s1_tag   <= '0;
         p_ir     <= '0;
         p_qi     <= '0;
         p_qr     <= '0;
         p_ii     <= '0;
      end else if (adv) begin
         s1_valid <= s0_valid;
         if (s0_valid) begin
            s1_conj <= s0_conj;
            s1_last <= s0_last;
            s1_tag  <= s0_tag;
            p_ir    <= PPW'(s0_i) * PPW'(cr);
            p_qi    <= PPW'(s0_q) * PPW'(ci);
            p_qr    <= PPW'(s0_q) * PPW'(cr);
            p_ii    <= PPW'(s0_i) * PPW'(ci);
         end
      end
   end

   // ---------------- S2: sums ----------------
   logic                 s2_valid, s2_last;
   logic [TAG_W-1:0]     s2_tag;
   logic signed [PW-1:0] s2_re, s2_im;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_tag   <= '0;
         s2_re    <= '0;
         s2_im    <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_last <= s1_last;
            s2_tag  <= s1_tag;
            if (s1_conj) begin
               s2_re <= PW'(p_ir) + PW'(p_qi);
               s2_im <= PW'(p_qr) - PW'(p_ii);
            end else begin
               s2_re <= PW'(p_ir) - PW'(p_qi);
               s2_im <= PW'(p_qr) + PW'(p_ii);
            end
         end
      end
   end

   // ---------------- S3: round / saturate into output register ----------------
   // Returns {clip, value}. One guard bit above PW keeps the rounding add exact.
   function automatic logic [OW:0] round_sat(input logic signed [PW-1:0] v);
      logic signed [RW-1:0] r;
      r = (RW'(v) + RND) >>> SHIFT;
      if (r > OMAX)      return {1'b1, OMAX_O};
      else if (r < OMIN) return {1'b1, OMIN_O};
      else               return {1'b0, r[OW-1:0]};
   endfunction

   logic [OW:0] rs_re, rs_im;

   assign rs_re = round_sat(s2_re);
   assign rs_im = round_sat(s2_im);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (adv) begin
         m_axis_tvalid <= s2_valid;
         if (s2_valid) begin
            m_axis_tdata <= {rs_im[OW-1:0], rs_re[OW-1:0]};
            m_axis_tuser <= {rs_re[OW] | rs_im[OW], s2_tag};
            m_axis_tlast <= s2_last;
         end
      end
   end

endmodule
